// File: rtl/hetic_pkg.sv
// -----------------------------------------------------------------------------
// hetic_pkg
// Shared types and default widths for the HETI interrupt sequencer slice.
//   irq_stack_entry_t : one nesting-stack entry {level, nest}
//   seq_state_e       : sequencer FSM states
// The stack entry width follows NR_IRQ_PRIOS below; the sequencer's
// NrIrqPrios parameter must stay equal to it.
// -----------------------------------------------------------------------------
package hetic_pkg;

   localparam int NR_IRQ_LINES = 64;
   localparam int NR_IRQ_PRIOS = 32;
   localparam int STACK_DEPTH  = 4;

   localparam int IRQ_W   = $clog2(NR_IRQ_LINES);
   localparam int PRIO_W  = $clog2(NR_IRQ_PRIOS);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   typedef struct packed {
      logic [PRIO_W-1:0] level;
      logic              nest;
   } irq_stack_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ACK   = 2'd2,
      GUARD = 2'd3
   } seq_state_e;

endpackage

// File: rtl/irq_level_stack.sv
// -----------------------------------------------------------------------------
// irq_level_stack
// Register stack of active interrupt levels.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i        : push entry_i (ignored when full)
//   pop_i         : pop top entry (ignored when empty)
//   entry_i       : entry to push
//   top_o         : top entry, all-zero when empty
//   depth_o       : number of valid entries
// Pop and push in the same cycle replace the top entry.
// -----------------------------------------------------------------------------
module irq_level_stack
   import hetic_pkg::*;
#(
   parameter  int StackDepth = STACK_DEPTH,
   localparam int DepthWidth = $clog2(StackDepth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  irq_stack_entry_t      entry_i,
   output irq_stack_entry_t      top_o,
   output logic [DepthWidth-1:0] depth_o
);

   localparam logic [DepthWidth-1:0] FULL = DepthWidth'(StackDepth);

   irq_stack_entry_t [StackDepth-1:0] mem_q, mem_d;
   logic [DepthWidth-1:0]             depth_q, depth_d;

   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      // Pop first so a same-cycle push lands in the slot just freed.
      if (pop_i && depth_q != '0) depth_d = depth_q - DepthWidth'(1);
      if (push_i && depth_d != FULL) begin
         for (int i = 0; i < StackDepth; i++)
            if (i == int'(depth_d)) mem_d[i] = entry_i;
         depth_d = depth_d + DepthWidth'(1);
      end
   end

   always_comb begin
      top_o = '0;
      for (int i = 0; i < StackDepth; i++)
         if (i + 1 == int'(depth_q)) top_o = mem_q[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q   <= '0;
         depth_q <= '0;
      end else begin
         mem_q   <= mem_d;
         depth_q <= depth_d;
      end
   end

   assign depth_o = depth_q;

endmodule

// File: rtl/hetic_irq_sequencer.sv
// -----------------------------------------------------------------------------
// hetic_irq_sequencer
// Core-side claim sequencer for the HETI interrupt controller: decides
// preemption, requests trap entry, acks the claimed line and tracks nesting.
//   irq_valid/id/level/heti/nest_i : arbitrated winner from the controller
//   irq_ack_o, irq_id_o            : one-cycle claim pulse + claimed id
//   irq_req_o, irq_req_id/heti_o   : trap request to the core
//   core_mie_i, core_take_i,
//   core_mret_i                    : core enable, trap commit, handler exit
//   level_o, depth_o               : running level / nesting depth
//   err_o                          : sticky, mret seen at depth 0
//   lat_max_o                      : worst request-to-take latency
// Optional feature macro: HETIC_IRQ_LAT_STATS_EN (latency statistics);
// without it lat_max_o is tied to zero.
// -----------------------------------------------------------------------------
module hetic_irq_sequencer
   import hetic_pkg::*;
#(
   parameter  int NrIrqLines = NR_IRQ_LINES,
   parameter  int NrIrqPrios = NR_IRQ_PRIOS,
   parameter  int StackDepth = STACK_DEPTH,
   localparam int IrqWidth   = $clog2(NrIrqLines),
   localparam int PrioWidth  = $clog2(NrIrqPrios),
   localparam int DepthWidth = $clog2(StackDepth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  irq_valid_i,
   input  logic [IrqWidth-1:0]   irq_id_i,
   input  logic [PrioWidth-1:0]  irq_level_i,
   input  logic                  irq_heti_i,
   input  logic                  irq_nest_i,
   output logic                  irq_ack_o,
   output logic [IrqWidth-1:0]   irq_id_o,
   output logic                  irq_req_o,
   output logic [IrqWidth-1:0]   irq_req_id_o,
   output logic                  irq_req_heti_o,
   input  logic                  core_mie_i,
   input  logic                  core_take_i,
   input  logic                  core_mret_i,
   output logic [PrioWidth-1:0]  level_o,
   output logic [DepthWidth-1:0] depth_o,
   output logic                  err_o,
   output logic [15:0]           lat_max_o
);

   localparam logic [DepthWidth-1:0] FULL = DepthWidth'(StackDepth);

   seq_state_e            state_q, state_d;
   logic [IrqWidth-1:0]   id_q, id_d;
   logic [PrioWidth-1:0]  lvl_q, lvl_d;
   logic                  heti_q, heti_d, nest_q, nest_d;
   logic                  req_q, req_d, ack_q, ack_d, err_q, err_d;
   logic [IrqWidth-1:0]   ack_id_q, ack_id_d;
   logic                  push, eligible, take;
   irq_stack_entry_t      top;
   logic [DepthWidth-1:0] depth;

   irq_level_stack #(.StackDepth(StackDepth)) u_stack (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .pop_i   (core_mret_i),
      .entry_i ('{level: lvl_q, nest: nest_q}),
      .top_o   (top),
      .depth_o (depth)
   );

   assign eligible = irq_valid_i & core_mie_i & (depth != FULL) &
                     ((depth == '0) | (top.nest & (irq_level_i > top.level)));

   // The core may only commit once it can see the request; the first REQ
   // cycle (request not yet visible) just re-qualifies the winner.
   assign take = core_take_i & req_q;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      lvl_d   = lvl_q;
      heti_d  = heti_q;
      nest_d  = nest_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: if (eligible) begin
            id_d    = irq_id_i;
            lvl_d   = irq_level_i;
            heti_d  = irq_heti_i;
            nest_d  = irq_nest_i;
            state_d = REQ;
         end
         REQ: begin
            if (take) begin
               push    = 1'b1;
               state_d = ACK;
            end else if (!irq_valid_i || irq_id_i != id_q || !eligible) begin
               state_d = IDLE;
            end
         end
         ACK:     state_d = GUARD;
         GUARD:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      req_d    = (state_q == REQ) && (state_d == REQ);
      ack_d    = (state_d == ACK);
      ack_id_d = ack_d ? id_q : '0;
      err_d    = err_q | (core_mret_i & (depth == '0));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         id_q     <= '0;
         lvl_q    <= '0;
         heti_q   <= 1'b0;
         nest_q   <= 1'b0;
         req_q    <= 1'b0;
         ack_q    <= 1'b0;
         ack_id_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         lvl_q    <= lvl_d;
         heti_q   <= heti_d;
         nest_q   <= nest_d;
         req_q    <= req_d;
         ack_q    <= ack_d;
         ack_id_q <= ack_id_d;
         err_q    <= err_d;
      end
   end

`ifdef HETIC_IRQ_LAT_STATS_EN
   logic [15:0] cnt_q, lat_q, cnt_inc;

   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   // Count cycles spent in REQ; a withdrawal leaves REQ and the count restarts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         lat_q <= '0;
      end else if (state_q == REQ) begin
         cnt_q <= take ? 16'd0 : cnt_inc;
         if (take && cnt_inc > lat_q) lat_q <= cnt_inc;
      end else begin
         cnt_q <= '0;
      end
   end

   assign lat_max_o = lat_q;
`else
   assign lat_max_o = 16'h0;
`endif

   assign irq_ack_o      = ack_q;
   assign irq_id_o       = ack_id_q;
   assign irq_req_o      = req_q;
   assign irq_req_id_o   = id_q;
   assign irq_req_heti_o = heti_q;
   assign level_o        = top.level;
   assign depth_o        = depth;
   assign err_o          = err_q;

endmodule

// File: tb/tb_hetic_irq_sequencer.sv
module tb_hetic_irq_sequencer;
   localparam int SD = 4;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       valid = 0, heti = 0, nest = 0, mie = 0, take = 0, mret = 0;
   logic [5:0] id = '0;
   logic [4:0] lvl = '0;
   logic       ack_o, req_o, req_heti_o, err_o;
   logic [5:0] id_o, req_id_o;
   logic [4:0] level_o;
   logic [2:0] depth_o;
   logic [15:0] lat_max_o;

   always #5 clk = ~clk;

   hetic_irq_sequencer dut (
      .clk_i(clk), .rst_ni(rst_n),
      .irq_valid_i(valid), .irq_id_i(id), .irq_level_i(lvl),
      .irq_heti_i(heti), .irq_nest_i(nest),
      .irq_ack_o(ack_o), .irq_id_o(id_o),
      .irq_req_o(req_o), .irq_req_id_o(req_id_o), .irq_req_heti_o(req_heti_o),
      .core_mie_i(mie), .core_take_i(take), .core_mret_i(mret),
      .level_o(level_o), .depth_o(depth_o), .err_o(err_o), .lat_max_o(lat_max_o)
   );

   // Reference model: nesting stack as a queue of {level, nest}.
   typedef struct { int level; bit nest; } ent_t;
   ent_t stk[$];
   bit   m_err;
   int   exp_ack[$];
   int   n_chk = 0, n_pass = 0;

   function automatic void chk(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   function automatic bit m_elig(int l);
      if (!mie || stk.size() >= SD) return 0;
      if (stk.size() == 0) return 1;
      return stk[$].nest && (l > stk[$].level);
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk_stack();
      chk("depth", depth_o, stk.size());
      chk("level", level_o, stk.size() ? stk[$].level : 0);
      chk("err", err_o, m_err);
   endtask

   // Scoreboard monitor: every ack pulse must match the oldest taken id.
   always @(negedge clk) begin
      if (rst_n && ack_o) begin
         if (exp_ack.size() == 0) begin
            n_chk++;
            $display("FAIL ack_unexpected: got ack id %0d expected none", id_o);
         end else begin
            chk("ack_id", id_o, exp_ack.pop_front());
         end
      end
   end

   // mode 0: leave untaken (withdraw), 1: take, 2: take with same-cycle mret
   task automatic offer(int i, int l, bit n, bit h, int mode);
      bit e = m_elig(l);
      int seen = 0;
      id = 6'(i); lvl = 5'(l); nest = n; heti = h; valid = 1;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (req_o) begin seen = k; break; end
      end
      if (e) begin
         chk("req_latency", seen, 2);
         if (seen != 0) begin
            chk("req_id", req_id_o, i);
            chk("req_heti", req_heti_o, h);
         end
      end else begin
         chk("no_req", seen, 0);
      end
      if (seen != 0 && mode != 0) begin
         take = 1; mret = (mode == 2);
         exp_ack.push_back(i);
         step();
         take = 0; mret = 0; valid = 0;
         if (mode == 2) begin
            if (stk.size() > 0) void'(stk.pop_back()); else m_err = 1;
         end
         stk.push_back('{level: l, nest: n});
         chk("ack_pulse", ack_o, 1);
         chk("req_drop_on_take", req_o, 0);
         chk_stack();
         step();
         chk("ack_single", ack_o, 0);
         step();
      end else begin
         valid = 0;
         step();
         chk("req_idle", req_o, 0);
         step();
      end
   endtask

   task automatic do_mret();
      mret = 1;
      step();
      mret = 0;
      if (stk.size() > 0) void'(stk.pop_back()); else m_err = 1;
      chk_stack();
   endtask

   initial begin
      int seen;
      step(); step();
      chk("rst_req", req_o, 0);
      chk("rst_ack", ack_o, 0);
      chk("rst_id", id_o, 0);
      chk("rst_req_id", req_id_o, 0);
      chk("rst_heti", req_heti_o, 0);
      chk_stack();
      rst_n = 1;
      mie = 1;
      step();

      // basic claim, preemption, no preemption at lower level
      offer(5, 3, 1, 0, 1);
      offer(9, 7, 1, 1, 1);
      offer(2, 5, 1, 0, 1);
      do_mret(); do_mret();

      // non-nestable handler blocks everything; mie=0 blocks at depth 0
      offer(4, 3, 0, 0, 1);
      offer(8, 7, 1, 0, 1);
      do_mret();
      mie = 0;
      offer(3, 1, 1, 0, 1);
      mie = 1;

      // winner changes while requesting -> withdraw, then re-request
      id = 6'd5; lvl = 5'd2; nest = 1; heti = 0; valid = 1;
      step(); step();
      chk("sw_req_first", req_o, 1);
      id = 6'd6;
      step();
      chk("sw_withdraw", req_o, 0);
      seen = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (req_o) begin seen = k; break; end
      end
      chk("sw_rereq_latency", seen, 2);
      chk("sw_rereq_id", req_id_o, 6);
      take = 1; exp_ack.push_back(6);
      step();
      take = 0; valid = 0;
      stk.push_back('{level: 2, nest: 1});
      chk_stack();
      step(); step();
      do_mret();

      // fill the stack, full blocks a higher level, underflow sets err
      for (int k = 1; k <= SD; k++) offer(10 + k, k, 1, 0, 1);
      offer(20, 9, 1, 0, 1);
      for (int k = 0; k < SD; k++) do_mret();
      do_mret();

      // mret + take together replaces the top
      offer(30, 2, 1, 0, 1);
      offer(31, 6, 1, 1, 2);
      do_mret();

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         mie = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) < 7)
            offer(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)));
         else
            do_mret();
      end
      mie = 1;

      // asynchronous reset while a request is pending
      while (stk.size() > 0) do_mret();
      id = 6'd7; lvl = 5'd4; nest = 1; heti = 1; valid = 1;
      step(); step();
      chk("pre_reset_req", req_o, 1);
      #2 rst_n = 0;
      #1;
      valid = 0;
      stk.delete(); m_err = 0;
      chk("arst_req", req_o, 0);
      chk("arst_req_id", req_id_o, 0);
      chk("arst_heti", req_heti_o, 0);
      chk("arst_ack", ack_o, 0);
      chk_stack();
      step();
      rst_n = 1;
      step();
      chk("sb_drained", exp_ack.size(), 0);
`ifndef HETIC_IRQ_LAT_STATS_EN
      chk("lat_tied", lat_max_o, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
